// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite transfer/response encodings and default-slave state type
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_OK   = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  // Only NONSEQ/SEQ carry a real transfer; IDLE/BUSY always get a zero-wait OKAY.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// rtl/ahb_default_slave.sv - default slave producing the two-cycle ERROR for unmapped transfers
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic HCLK,
  input  logic HRESET,
  input  logic accept,
  input  logic unmapped_active,
  output logic ds_hready,
  output logic ds_hresp
);

  ds_state_e state;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= DS_OK;
      ds_hready <= 1'b1;
      ds_hresp  <= HRESP_OKAY;
    end else begin
      case (state)
        // DS_ERR2 is itself an accepting cycle, so it re-evaluates exactly like DS_OK.
        DS_OK, DS_ERR2: begin
          if (accept && unmapped_active) begin
            state     <= DS_ERR1;
            ds_hready <= 1'b0;
            ds_hresp  <= HRESP_ERROR;
          end else if (accept) begin
            state     <= DS_OK;
            ds_hready <= 1'b1;
            ds_hresp  <= HRESP_OKAY;
          end
        end
        DS_ERR1: begin
          state     <= DS_ERR2;
          ds_hready <= 1'b1;
          ds_hresp  <= HRESP_ERROR;
        end
        default: begin
          state     <= DS_OK;
          ds_hready <= 1'b1;
          ds_hresp  <= HRESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_resp_mux_n.sv
// rtl/ahb_resp_mux_n.sv - AHB-Lite slave-to-master response mux with data-phase select and default slave
module ahb_resp_mux_n
  import ahb_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic [NUM_SLAVES-1:0]            HSEL_VEC,
  input  logic [1:0]                       HTRANS,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]            HRESP_S,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  output logic                             HREADY,
  output logic                             HRESP,
  output logic                             SEL_CONFLICT
);

  localparam int IDX_W = $clog2(NUM_SLAVES + 1);
  localparam logic [IDX_W-1:0] DSEL_DEFAULT = IDX_W'(NUM_SLAVES);

  logic [IDX_W-1:0]      dsel;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_any;
  logic                  sel_multi;
  logic                  accept;
  logic                  unmapped_active;
  logic                  ds_hready;
  logic                  ds_hresp;
  logic [DATA_WIDTH-1:0] hrdata_mux;
  logic                  hready_mux;
  logic                  hresp_mux;

  // Lowest set index wins; a second set bit only flags the conflict.
  always_comb begin
    sel_idx   = DSEL_DEFAULT;
    sel_any   = 1'b0;
    sel_multi = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (HSEL_VEC[i]) begin
        if (sel_any) sel_multi = 1'b1;
        else         sel_idx   = IDX_W'(i);
        sel_any = 1'b1;
      end
    end
  end

  assign accept          = hready_mux;
  assign unmapped_active = !sel_any && htrans_active(HTRANS);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel         <= DSEL_DEFAULT;
      SEL_CONFLICT <= 1'b0;
    end else begin
      SEL_CONFLICT <= accept && sel_multi;
      if (accept) dsel <= sel_idx;
    end
  end

  ahb_default_slave u_default_slave (
    .HCLK            (HCLK),
    .HRESET          (HRESET),
    .accept          (accept),
    .unmapped_active (unmapped_active),
    .ds_hready       (ds_hready),
    .ds_hresp        (ds_hresp)
  );

  // Response path depends on the address phase only through the registered dsel.
  always_comb begin
    hrdata_mux = '0;
    hready_mux = ds_hready;
    hresp_mux  = ds_hresp;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel == IDX_W'(i)) begin
        hrdata_mux = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
        hready_mux = HREADYOUT_S[i];
        hresp_mux  = HRESP_S[i];
      end
    end
  end

  assign HRDATA = hrdata_mux;
  assign HREADY = hready_mux;
  assign HRESP  = hresp_mux;

endmodule

// File: tb/tb_ahb_resp_mux_n.sv
// tb/tb_ahb_resp_mux_n.sv - self-checking bench for ahb_resp_mux_n
module tb_ahb_resp_mux_n;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   hsel;
  logic [1:0]   htrans;
  logic [127:0] rdata_s;
  logic [3:0]   rdy_s;
  logic [3:0]   resp_s;
  logic [31:0]  hrdata;
  logic         hready, hresp, conf;

  logic [0:0]    hsel1;
  logic [31:0]   rdata1_s;
  logic [31:0]   hrdata1;
  logic          hready1, hresp1, conf1;
  logic [15:0]   hsel16;
  logic [1023:0] rdata16_s;
  logic [63:0]   hrdata16;
  logic          hready16, hresp16, conf16;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign hsel1  = hsel[0];
  assign hsel16 = {12'h000, hsel};

  ahb_resp_mux_n #(.NUM_SLAVES(4), .DATA_WIDTH(32)) dut (
    .HCLK(clk), .HRESET(rst), .HSEL_VEC(hsel), .HTRANS(htrans),
    .HRDATA_S(rdata_s), .HREADYOUT_S(rdy_s), .HRESP_S(resp_s),
    .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp), .SEL_CONFLICT(conf)
  );

  ahb_resp_mux_n #(.NUM_SLAVES(1), .DATA_WIDTH(32)) dut1 (
    .HCLK(clk), .HRESET(rst), .HSEL_VEC(hsel1), .HTRANS(htrans),
    .HRDATA_S(rdata1_s), .HREADYOUT_S(1'b1), .HRESP_S(1'b0),
    .HRDATA(hrdata1), .HREADY(hready1), .HRESP(hresp1), .SEL_CONFLICT(conf1)
  );

  ahb_resp_mux_n #(.NUM_SLAVES(16), .DATA_WIDTH(64)) dut16 (
    .HCLK(clk), .HRESET(rst), .HSEL_VEC(hsel16), .HTRANS(htrans),
    .HRDATA_S(rdata16_s), .HREADYOUT_S(16'hFFFF), .HRESP_S(16'h0000),
    .HRDATA(hrdata16), .HREADY(hready16), .HRESP(hresp16), .SEL_CONFLICT(conf16)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // Model: who owns the current data phase (-1 = default slave) and how far into
  // the two-cycle error response the default slave is (0 none, 1 first, 2 second).
  int m_owner = -1;
  int m_err = 0;
  bit m_conf = 0;
  bit m_valid = 0;

  function automatic bit m_ready();
    if (m_owner >= 0) return rdy_s[m_owner];
    return m_err != 1;
  endfunction

  function automatic bit m_resp();
    if (m_owner >= 0) return resp_s[m_owner];
    return m_err != 0;
  endfunction

  function automatic logic [31:0] m_data();
    if (m_owner >= 0) return rdata_s[m_owner*32 +: 32];
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_err = 0; m_conf = 0; m_valid = 1;
    end else if (m_valid) begin
      if (m_ready()) begin
        m_conf  = $countones(hsel) > 1;
        m_owner = -1;
        for (int i = 3; i >= 0; i--) if (hsel[i]) m_owner = i;
        m_err = (m_owner < 0 && htrans[1]) ? 1 : 0;
      end else begin
        m_conf = 0;
        if (m_owner < 0 && m_err == 1) m_err = 2;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_hready", {63'b0, hready}, {63'b0, m_ready()});
      chk("cyc_hresp",  {63'b0, hresp},  {63'b0, m_resp()});
      chk("cyc_hrdata", {32'b0, hrdata}, {32'b0, m_data()});
      chk("cyc_conf",   {63'b0, conf},   {63'b0, m_conf});
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [3:0] s, input logic [1:0] t);
    hsel = s; htrans = t; #1;
  endtask

  initial begin
    rst = 1'b1; hsel = 4'h0; htrans = 2'b00;
    rdata_s = {$urandom(), $urandom(), $urandom(), $urandom()};
    rdy_s = 4'($urandom()); resp_s = 4'($urandom());
    rdata1_s = 32'h1111_0000;
    for (int i = 0; i < 16; i++) rdata16_s[i*64 +: 64] = {32'hFEED_0000, 32'(i)};

    // 1: reset with random slave inputs
    tick(); tick();
    chk("rst_hready", {63'b0, hready}, 64'd1);
    chk("rst_hresp",  {63'b0, hresp},  64'd0);
    chk("rst_hrdata", {32'b0, hrdata}, 64'd0);
    chk("rst_conf",   {63'b0, conf},   64'd0);

    rst = 1'b0;
    for (int i = 0; i < 4; i++) rdata_s[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);
    rdy_s = 4'hF; resp_s = 4'h0;

    // 2: pipelining
    drive(4'b0100, 2'b10);
    tick(); drive(4'b0001, 2'b10);
    chk("pipe_s2", {32'b0, hrdata}, 64'hA5A5_0002);
    tick(); drive(4'b0000, 2'b00);
    chk("pipe_s0", {32'b0, hrdata}, 64'hA5A5_0000);
    tick();
    chk("pipe_idle", {30'b0, hready, hresp, hrdata}, {30'b0, 2'b10, 32'h0});

    // 3: wait states on slave 1 while HSEL_VEC moves
    drive(4'b0010, 2'b10);
    tick(); rdy_s[1] = 1'b0; drive(4'b0100, 2'b11);
    chk("wait_c1", {31'b0, hready, hrdata}, {31'b0, 1'b0, 32'hA5A5_0001});
    tick(); drive(4'b1000, 2'b11);
    chk("wait_c2", {31'b0, hready, hrdata}, {31'b0, 1'b0, 32'hA5A5_0001});
    tick(); drive(4'b0001, 2'b11);
    chk("wait_c3", {31'b0, hready, hrdata}, {31'b0, 1'b0, 32'hA5A5_0001});
    tick(); rdy_s[1] = 1'b1; drive(4'b0100, 2'b10);
    chk("wait_done", {31'b0, hready, hrdata}, {31'b0, 1'b1, 32'hA5A5_0001});
    tick(); drive(4'b0000, 2'b10);
    chk("wait_next", {32'b0, hrdata}, 64'hA5A5_0002);

    // 4: unmapped NONSEQ, back-to-back SEQ, IDLE
    tick(); drive(4'b0000, 2'b00);
    chk("unm_a", {62'b0, hready, hresp}, 64'b01);
    tick(); chk("unm_b", {62'b0, hready, hresp}, 64'b11);
    tick(); chk("unm_c", {62'b0, hready, hresp}, 64'b10);
    drive(4'b0000, 2'b11);
    tick(); chk("b2b_a", {62'b0, hready, hresp}, 64'b01);
    tick(); chk("b2b_b", {62'b0, hready, hresp}, 64'b11);
    tick(); drive(4'b0000, 2'b00);
    chk("b2b_c", {62'b0, hready, hresp}, 64'b01);
    tick(); chk("b2b_d", {62'b0, hready, hresp}, 64'b11);
    tick(); chk("b2b_e", {62'b0, hready, hresp}, 64'b10);
    tick(); chk("idle_unm", {30'b0, hready, hresp, hrdata}, {30'b0, 2'b10, 32'h0});

    // 5: conflict
    drive(4'b1010, 2'b10);
    tick(); drive(4'b0000, 2'b00);
    chk("conf_set", {31'b0, conf, hrdata}, {31'b0, 1'b1, 32'hA5A5_0001});
    tick(); chk("conf_clr", {63'b0, conf}, 64'd0);

    // 6: reset in the first error cycle, all three parameter sets
    drive(4'b0000, 2'b10);
    tick();
    chk("me4_err1",  {62'b0, hready, hresp},     64'b01);
    chk("me1_err1",  {62'b0, hready1, hresp1},   64'b01);
    chk("me16_err1", {62'b0, hready16, hresp16}, 64'b01);
    rst = 1'b1;
    tick(); rst = 1'b0; drive(4'b0000, 2'b00);
    chk("me4_rst",  {30'b0, hready, hresp, hrdata},     {30'b0, 2'b10, 32'h0});
    chk("me1_rst",  {30'b0, hready1, hresp1, hrdata1},  {30'b0, 2'b10, 32'h0});
    chk("me16_rst", {hready16, hresp16, hrdata16[61:0]}, {2'b10, 62'h0});
    chk("me16_hi",  {62'b0, hrdata16[63:62]},           64'h0);

    // Random traffic, checked by the model every cycle
    for (int n = 0; n < 300; n++) begin
      tick();
      rst = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0:       hsel = 4'h0;
        1:       hsel = 4'b0001 << $urandom_range(0, 3);
        default: hsel = 4'($urandom());
      endcase
      htrans = 2'($urandom());
      rdy_s  = 4'($urandom()) | 4'($urandom());
      resp_s = 4'($urandom()) & 4'($urandom());
      rdata_s = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    tick(); rst = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
